// File: rtl/router_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_pkg : shared types and defaults for the router rx endpoint |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package router_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int NBITS_W_DEF = $clog2(DATA_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]  data;
    logic [NBITS_W_DEF-1:0] nbits;
    logic                   last;
  } rx_word_t;

endpackage
`default_nettype wire

// File: rtl/router_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_rx_fifo : first-word-fall-through sync FIFO, full/empty   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int W     = $bits(rx_word_t),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din_i;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_port_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_port_rx : serial-to-word receive endpoint for a router    |
// |                  output port, FIFO-buffered valid/ready output.  |
// | Optional stats counters: define ROUTER_RX_STATS_EN               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module router_port_rx
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         dout_i,
  input  logic                         frameo_n_i,
  input  logic                         valido_n_i,
  output logic [DATA_W-1:0]            word_o,
  output logic [$clog2(DATA_W+1)-1:0]  word_nbits_o,
  output logic                         word_last_o,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic                         busy_o,
  output logic                         err_abort_o,
  output logic                         err_ovf_o
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [15:0]                  pkt_cnt_o,
  output logic [15:0]                  err_cnt_o
`endif
);

  localparam int              CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CW-1:0]     nbits;
    logic              last;
  } word_t;

  rx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_w;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              push_q, push_d;
  word_t             pword_q, pword_d;
  logic              abort_q, abort_d;
  logic              ovf_q, ovf_d;
  logic              armed_q, armed_d;
  logic              capture, fin_bit;
  logic              fifo_full, fifo_empty, pop, ovf_ev;
  word_t             head;

  assign pop    = word_valid_o && word_ready_i;
  assign ovf_ev = push_q && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    push_d  = 1'b0;
    pword_d = pword_q;
    abort_d = 1'b0;
    ovf_d   = ovf_q | ovf_ev;
    // After reset the remainder of an interrupted frame must not look like a new packet.
    armed_d = armed_q | frameo_n_i;
    capture = 1'b0;
    fin_bit = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    shreg_w = shreg_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_q == CW'(i)) shreg_w[i] = dout_i;
    end

    unique case (state_q)
      IDLE: begin
        if (armed_q && !frameo_n_i) begin
          state_d = RECV;
          capture = !valido_n_i;
        end
      end
      RECV: begin
        if (frameo_n_i) begin
          state_d = IDLE;
          if (valido_n_i) begin
            abort_d = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            capture = 1'b1;
            fin_bit = 1'b1;
          end
        end else begin
          capture = !valido_n_i;
        end
      end
      DROP: begin
        if (frameo_n_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (fin_bit || cnt_inc == CNT_FULL) begin
        push_d  = 1'b1;
        pword_d = '{data: shreg_w, nbits: cnt_inc, last: fin_bit};
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = shreg_w;
        cnt_d   = cnt_inc;
      end
    end

    // A dropped mid-packet word makes the rest of the frame meaningless.
    if (ovf_ev && !pword_q.last) begin
      state_d = frameo_n_i ? IDLE : DROP;
      shreg_d = '0;
      cnt_d   = '0;
      push_d  = 1'b0;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      push_q  <= 1'b0;
      pword_q <= '0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      pword_q <= pword_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
    end
  end

  router_rx_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_q),
    .din_i   (pword_q),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_o       = head.data;
  assign word_nbits_o = head.nbits;
  assign word_last_o  = head.last;
  assign word_valid_o = !fifo_empty;
  assign busy_o       = (state_q != IDLE);
  assign err_abort_o  = abort_q;
  assign err_ovf_o    = ovf_q;

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push_q && !ovf_ev && pword_q.last && pkt_cnt_q != 16'hFFFF) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if ((abort_d || ovf_ev) && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_port_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_router_port_rx : directed, table-driven bench (DATA_W=8,D=4)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_router_port_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dout_i = 1'b0;
  logic       frameo_n_i = 1'b1;
  logic       valido_n_i = 1'b1;
  logic       word_ready_i = 1'b0;
  logic [7:0] word_o;
  logic [3:0] word_nbits_o;
  logic       word_last_o, word_valid_o, busy_o, err_abort_o, err_ovf_o;
`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt_o, err_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  typedef struct {
    logic [63:0] bits;
    int          n;
    bit          gaps;
    int          nw;
    logic [15:0] d;
    logic [7:0]  nb;
    logic [1:0]  l;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  router_port_rx #(.DATA_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dout_i       (dout_i),
    .frameo_n_i   (frameo_n_i),
    .valido_n_i   (valido_n_i),
    .word_o       (word_o),
    .word_nbits_o (word_nbits_o),
    .word_last_o  (word_last_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .busy_o       (busy_o),
    .err_abort_o  (err_abort_o),
    .err_ovf_o    (err_ovf_o)
`ifdef ROUTER_RX_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt_o),
    .err_cnt_o    (err_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [63:0] bits, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      dout_i     = bits[i];
      valido_n_i = 1'b0;
      frameo_n_i = (i == n - 1);
      tick();
      if (gaps && i < n - 1) begin
        valido_n_i = 1'b1;
        dout_i     = 1'b0;
        tick();
      end
    end
    valido_n_i = 1'b1;
    frameo_n_i = 1'b1;
    dout_i     = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic [3:0] nb, input logic l);
    chk({tag, " valid"}, 32'(word_valid_o), 32'd1);
    chk({tag, " data"},  32'(word_o),       32'(d));
    chk({tag, " nbits"}, 32'(word_nbits_o), 32'(nb));
    chk({tag, " last"},  32'(word_last_o),  32'(l));
    word_ready_i = 1'b1;
    tick();
    word_ready_i = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef ROUTER_RX_STATS_EN
    chk({tag, " pkt_cnt"}, 32'(pkt_cnt_o), 32'(exp_pkt));
    chk({tag, " err_cnt"}, 32'(err_cnt_o), 32'(exp_err));
`else
    chk({tag, " ovf_vs_errs"}, 32'(err_ovf_o), 32'(exp_err > 1));
`endif
  endtask

  initial begin
    vecs[0] = '{bits: 64'h3,    n: 3,  gaps: 1'b1, nw: 1, d: 16'h0003, nb: 8'h03, l: 2'b01};
    vecs[1] = '{bits: 64'h3CA5, n: 16, gaps: 1'b0, nw: 2, d: 16'h3CA5, nb: 8'h88, l: 2'b10};
    vecs[2] = '{bits: 64'h1FF,  n: 9,  gaps: 1'b0, nw: 2, d: 16'h01FF, nb: 8'h18, l: 2'b10};
    vecs[3] = '{bits: 64'h55,   n: 7,  gaps: 1'b0, nw: 1, d: 16'h0055, nb: 8'h07, l: 2'b01};
    vecs[4] = '{bits: 64'h96,   n: 8,  gaps: 1'b1, nw: 1, d: 16'h0096, nb: 8'h08, l: 2'b01};

    // Reset state
    tick();
    tick();
    chk("rst valid", 32'(word_valid_o), 0);
    chk("rst busy",  32'(busy_o), 0);
    chk("rst abort", 32'(err_abort_o), 0);
    chk("rst ovf",   32'(err_ovf_o), 0);
    chk("rst word",  32'(word_o), 0);
    chk_stats("rst");
    reset_n = 1'b1;
    tick();

    // 8-bit packet 0x4D with ready high: check one-cycle push latency
    word_ready_i = 1'b1;
    send_pkt(64'h4D, 8, 1'b0);
    chk("t1 latency valid", 32'(word_valid_o), 0);
    chk("t1 busy after final", 32'(busy_o), 0);
    tick();
    chk("t1 valid", 32'(word_valid_o), 1);
    chk("t1 data",  32'(word_o), 32'h4D);
    chk("t1 nbits", 32'(word_nbits_o), 8);
    chk("t1 last",  32'(word_last_o), 1);
    tick();
    chk("t1 drained", 32'(word_valid_o), 0);
    word_ready_i = 1'b0;
    exp_pkt++;

    // Table-driven packets, buffered with ready low then drained
    for (int i = 0; i < 5; i++) begin
      send_pkt(vecs[i].bits, vecs[i].n, vecs[i].gaps);
      chk($sformatf("vec%0d busy", i), 32'(busy_o), 0);
      tick();
      tick();
      for (int w = 0; w < vecs[i].nw; w++) begin
        expect_word($sformatf("vec%0d w%0d", i, w), vecs[i].d[w*8 +: 8],
                    vecs[i].nb[w*4 +: 4], vecs[i].l[w]);
      end
      chk($sformatf("vec%0d empty", i), 32'(word_valid_o), 0);
      exp_pkt++;
    end

    // Abort: frame rises without a valid bit after 5 bits
    for (int i = 0; i < 5; i++) begin
      dout_i = 1'b1; valido_n_i = 1'b0; frameo_n_i = 1'b0;
      tick();
    end
    chk("abort busy mid", 32'(busy_o), 1);
    valido_n_i = 1'b1; frameo_n_i = 1'b1;
    tick();
    chk("abort pulse", 32'(err_abort_o), 1);
    tick();
    chk("abort pulse end", 32'(err_abort_o), 0);
    chk("abort no word", 32'(word_valid_o), 0);
    exp_err++;
    send_pkt(64'h1A, 5, 1'b0);
    tick();
    tick();
    expect_word("post-abort", 8'h1A, 4'd5, 1'b1);
    exp_pkt++;
    chk_stats("abort");

    // Overflow: six full words with ready low
    send_pkt(64'h665544332211, 48, 1'b0);
    tick();
    chk("ovf flag", 32'(err_ovf_o), 1);
    chk("ovf busy", 32'(busy_o), 0);
    expect_word("ovf w0", 8'h11, 4'd8, 1'b0);
    expect_word("ovf w1", 8'h22, 4'd8, 1'b0);
    expect_word("ovf w2", 8'h33, 4'd8, 1'b0);
    expect_word("ovf w3", 8'h44, 4'd8, 1'b0);
    chk("ovf drained", 32'(word_valid_o), 0);
    chk("ovf sticky", 32'(err_ovf_o), 1);
    exp_err++;
    chk_stats("ovf");

    // Reset mid-packet; remainder of the frame must be ignored
    for (int i = 0; i < 4; i++) begin
      dout_i = 1'b1; valido_n_i = 1'b0; frameo_n_i = 1'b0;
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("mrst valid", 32'(word_valid_o), 0);
    chk("mrst busy",  32'(busy_o), 0);
    chk("mrst ovf",   32'(err_ovf_o), 0);
    chk("mrst word",  32'(word_o), 0);
    exp_pkt = 0;
    exp_err = 0;
    chk_stats("mrst");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dout_i = 1'b1; valido_n_i = 1'b0; frameo_n_i = 1'b0;
      tick();
    end
    chk("mrst tail busy", 32'(busy_o), 0);
    frameo_n_i = 1'b1;
    tick();
    valido_n_i = 1'b1;
    tick();
    tick();
    chk("mrst tail no word", 32'(word_valid_o), 0);
    // Stray valid bits while idle
    for (int i = 0; i < 3; i++) begin
      dout_i = 1'b1; valido_n_i = 1'b0; frameo_n_i = 1'b1;
      tick();
    end
    valido_n_i = 1'b1;
    tick();
    tick();
    chk("stray no word", 32'(word_valid_o), 0);
    chk("stray busy", 32'(busy_o), 0);
    send_pkt(64'h4D, 8, 1'b0);
    tick();
    tick();
    expect_word("post-reset", 8'h4D, 4'd8, 1'b1);
    exp_pkt++;
    chk_stats("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
